// File: rtl/reg_if_to_id.sv
// IF/ID pipeline boundary with an in-order skid buffer so fetch keeps running
// while decode stalls; flush drops everything buffered or held in ID.
module reg_if_to_id #(
  parameter int                  ADDR_WIDTH = 64,
  parameter int                  INST_WIDTH = 32,
  parameter int                  BUF_DEPTH  = 4,
  parameter logic [INST_WIDTH-1:0] NOP_INST = 32'h00000013
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic [ADDR_WIDTH-1:0] pc4,
  input  logic [INST_WIDTH-1:0] inst,
  input  logic                  inst_valid,
  output logic                  stage_if_stall,
  output logic                  inst_buffer_empty,
  output logic                  inst_buffer_full,
  output logic [ADDR_WIDTH-1:0] d_pc,
  output logic [ADDR_WIDTH-1:0] d_pc4,
  output logic [INST_WIDTH-1:0] d_inst,
  output logic                  d_valid
);

  localparam int              PTR_W    = $clog2(BUF_DEPTH);
  localparam logic [PTR_W:0]  CNT_FULL = (PTR_W+1)'(BUF_DEPTH);
  localparam logic [PTR_W:0]  CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [ADDR_WIDTH-1:0] r_buf_pc   [BUF_DEPTH];
  logic [ADDR_WIDTH-1:0] r_buf_pc4  [BUF_DEPTH];
  logic [INST_WIDTH-1:0] r_buf_inst [BUF_DEPTH];

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W:0]   r_count;

  logic [ADDR_WIDTH-1:0] r_id_pc;
  logic [ADDR_WIDTH-1:0] r_id_pc4;
  logic [INST_WIDTH-1:0] r_id_inst;
  logic                  r_id_valid;

  logic           w_empty;
  logic           w_full;
  logic           w_accept;
  logic           w_push;
  logic           w_pop;
  logic [PTR_W:0] w_count_nxt;

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == CNT_FULL);
  assign w_accept = inst_valid & ~flush & (~w_full | ~stall);

  // Anything accepted while ID is held, or while older entries are waiting,
  // must queue behind them; only an empty, advancing buffer may bypass.
  assign w_push = w_accept & (stall | ~w_empty);
  assign w_pop  = ~flush & ~stall & ~w_empty;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + CNT_ONE;
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_buf_pc[r_tail]   <= pc;
      r_buf_pc4[r_tail]  <= pc4;
      r_buf_inst[r_tail] <= inst;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PTR_ONE;
      if (w_pop)  r_head <= r_head + PTR_ONE;
      r_count <= w_count_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_id_pc    <= '0;
      r_id_pc4   <= '0;
      r_id_inst  <= NOP_INST;
      r_id_valid <= 1'b0;
    end else if (flush) begin
      r_id_inst  <= NOP_INST;
      r_id_valid <= 1'b0;
    end else if (!stall) begin
      if (!w_empty) begin
        r_id_pc    <= r_buf_pc[r_head];
        r_id_pc4   <= r_buf_pc4[r_head];
        r_id_inst  <= r_buf_inst[r_head];
        r_id_valid <= 1'b1;
      end else if (w_accept) begin
        r_id_pc    <= pc;
        r_id_pc4   <= pc4;
        r_id_inst  <= inst;
        r_id_valid <= 1'b1;
      end else begin
        r_id_inst  <= NOP_INST;
        r_id_valid <= 1'b0;
      end
    end
  end

  assign stage_if_stall    = inst_valid & w_full & stall;
  assign inst_buffer_empty = w_empty;
  assign inst_buffer_full  = w_full;
  assign d_pc              = r_id_pc;
  assign d_pc4             = r_id_pc4;
  assign d_inst            = r_id_inst;
  assign d_valid           = r_id_valid;

endmodule

// File: doc/reg_if_to_id.md
Name: reg_if_to_id

Overview:
- Pipeline boundary register between the fetch stage (stage_if) and the decode stage (stage_id / control_unit).
- Captures the fetched instruction, its PC and PC+4, and presents them to decode.
- A small in-order instruction buffer absorbs fetches that arrive while decode is stalled (load-use stall, GPU stall, coprocessor stall). Fetch therefore only has to stop when the buffer is full.
- Flush support discards wrong-path instructions after a redirect.

Parameters:
ADDR_WIDTH, 64, width of pc / pc4
INST_WIDTH, 32, instruction width
BUF_DEPTH, 4, instruction buffer entries; power of two, >= 2
NOP_INST, 32'h00000013, value driven on d_inst for a bubble (addi x0,x0,0)

Ports:
clk  input  1  clock, all state rising-edge
reset  input  1  asynchronous, active-high reset
stall  input  1  decode stall (stall | load_stall | cp_stall_request); hold the ID register
flush  input  1  discard all buffered and ID-held instructions (branch/trap redirect)
pc  input  ADDR_WIDTH  PC of fetched instruction
pc4  input  ADDR_WIDTH  pc + 4 from fetch
inst  input  INST_WIDTH  fetched instruction
inst_valid  input  1  inst/pc/pc4 are valid this cycle
stage_if_stall  output  1  fetch must hold its current instruction; it is not accepted
inst_buffer_empty  output  1  buffer holds 0 entries
inst_buffer_full  output  1  buffer holds BUF_DEPTH entries
d_pc  output  ADDR_WIDTH  PC of the instruction in ID
d_pc4  output  ADDR_WIDTH  PC+4 of the instruction in ID
d_inst  output  INST_WIDTH  instruction in ID (NOP_INST when bubble)
d_valid  output  1  the ID slot holds a real instruction

Behaviour:
- Reset (async, immediate):
  - d_pc = 0, d_pc4 = 0, d_inst = NOP_INST, d_valid = 0.
  - Buffer count, head and tail = 0, so inst_buffer_empty = 1 and inst_buffer_full = 0.
  - Reset asserted mid-operation drops all contents. No entry survives.
- Storage:
  - Buffer is a circular FIFO of {pc, pc4, inst}.
  - Head and tail are log2(BUF_DEPTH)-bit pointers that wrap modulo BUF_DEPTH.
  - count is (log2(BUF_DEPTH)+1) bits, range 0..BUF_DEPTH.
- Accept: accept = inst_valid & ~flush & (~inst_buffer_full | ~stall).
- stage_if_stall = inst_valid & inst_buffer_full & stall (combinational). Fetch holds pc/inst until it is accepted.
- Priority per rising edge: flush > stall > advance.
- flush = 1:
  - d_valid <= 0, d_inst <= NOP_INST; d_pc and d_pc4 are don't-care but hold.
  - head = tail = count = 0.
  - The inst presented the same cycle is dropped.
  - flush overrides stall.
- stall = 1, flush = 0:
  - The ID register holds all outputs.
  - If accept, the input is pushed at tail and count increments.
- stall = 0, flush = 0 (advance):
  - Buffer non-empty: the ID register loads the head entry and d_valid <= 1. Head advances. If accept, the input is pushed at tail the same edge and count is unchanged (simultaneous push/pop; valid when full).
  - Buffer empty and accept: bypass. The input loads directly into the ID register with d_valid <= 1, and the buffer is untouched. Latency fetch -> ID is 1 cycle.
  - Buffer empty and no input: the ID register becomes a bubble (d_valid <= 0, d_inst <= NOP_INST).
- Ordering: instructions reach ID strictly in fetch order. A buffered instruction always precedes a newer input.
- inst_buffer_empty and inst_buffer_full are derived from the registered count, so they are glitch-free.
- A push is never allowed to overwrite an unread entry. Count never exceeds BUF_DEPTH and never underflows.
- The block does no decode. rs1/rs2/rs3 fields are taken from d_inst outside this block.

Test Plan:
1. Reset then stream, no stall: pc = 0x1000, 0x1004, 0x1008 with inst_valid = 1. Each appears on d_pc/d_inst one cycle later with d_valid = 1; inst_buffer_empty stays 1 throughout.
2. Stall while d_inst = 0x00A00093 (pc 0x1000); feed 0x1004..0x1010 over 4 cycles. Outputs hold; count reaches 4 and inst_buffer_full = 1. A 5th input (pc 0x1014) raises stage_if_stall = 1 and is not accepted. After stall drops, ID shows 0x1004, 0x1008, 0x100C, 0x1010, 0x1014 on consecutive cycles.
3. Full buffer with stall = 0 and inst_valid = 1 on the same cycle: pop and push happen together. Count stays 4, stage_if_stall = 0, and order is preserved across pointer wrap (run 10 instructions through).
4. Flush with 3 entries buffered while stall = 1: next cycle d_valid = 0, d_inst = 0x00000013, inst_buffer_empty = 1. The next input (pc 0x2000) appears in ID after one cycle via bypass.
5. inst_valid = 0 with stall = 0 and the buffer empty: d_valid becomes 0 and d_inst = NOP_INST. Asserting reset asynchronously mid-stream with 2 entries buffered clears the outputs immediately, before the next clock edge.
